// File: rtl/sram_arbiter_if.sv
// Bus bundle for sram_arbiter: instruction requester, data requester,
// shared SRAM port and observation signals for the internal state.
// Handshake: a requester holds req and its payload stable until addr_ok is
// high in the same cycle (the request is accepted on that clock edge);
// data_ok is a one-cycle pulse exactly one cycle after acceptance, and the
// matching rdata is qualified by it (zero otherwise).
interface sram_arbiter_if;
    // instruction requester
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    // data requester
    logic        data_req;
    logic [3:0]  data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    // shared SRAM port
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    // internal state, zero-extended starvation count and response tracker
    logic [7:0]  dbg_starve_count;
    logic        dbg_resp_valid;
    logic        dbg_resp_owner;

    // arbiter side
    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_we, data_addr, data_wdata,
        input  sram_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata,
        output dbg_starve_count, dbg_resp_valid, dbg_resp_owner
    );

    // requester / memory side
    modport master (
        output inst_req, inst_addr,
        output data_req, data_we, data_addr, data_wdata,
        output sram_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata,
        input  dbg_starve_count, dbg_resp_valid, dbg_resp_owner
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for a single-ported synchronous SRAM.
// Data has priority; an instruction request denied STARVE_LIMIT cycles in a
// row wins the next contended cycle. Grants are combinational, responses
// return one cycle later through a one-entry tracker, so one access per
// cycle can be sustained. STARVE_LIMIT must lie in 1..255 so the count fits
// the 8-bit observation signal.
module sram_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          resetn,
    sram_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // tracker owner encoding
    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    logic [CNT_W-1:0] starve_cnt;
    logic             resp_valid;
    logic             resp_owner;
    logic             starved;
    logic             grant_inst;
    logic             grant_data;

    assign starved = (starve_cnt == CNT_MAX);

    // Pick the winner; nothing is granted while reset is held.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (resetn) begin
            if (bus.inst_req && (!bus.data_req || starved)) begin
                grant_inst = 1'b1;
            end else if (bus.data_req) begin
                grant_data = 1'b1;
            end
        end
    end

    // Steer the winner onto the SRAM port; idle port is driven all-zero.
    always_comb begin
        bus.sram_en    = 1'b0;
        bus.sram_we    = 4'h0;
        bus.sram_addr  = 32'h0;
        bus.sram_wdata = 32'h0;
        if (grant_data) begin
            bus.sram_en    = 1'b1;
            bus.sram_we    = bus.data_we;
            bus.sram_addr  = bus.data_addr;
            bus.sram_wdata = bus.data_wdata;
        end else if (grant_inst) begin
            bus.sram_en    = 1'b1;
            bus.sram_addr  = bus.inst_addr;
        end
    end

    assign bus.inst_addr_ok = grant_inst;
    assign bus.data_addr_ok = grant_data;

    // Count consecutive denied instruction cycles, saturating at the limit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= '0;
        end else if (!bus.inst_req || grant_inst) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + CNT_ONE;
        end
    end

    // Remember who was granted so the next cycle's SRAM data goes to them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_valid <= 1'b0;
            resp_owner <= OWNER_INST;
        end else begin
            resp_valid <= grant_inst || grant_data;
            resp_owner <= grant_data ? OWNER_DATA : OWNER_INST;
        end
    end

    assign bus.inst_data_ok = resp_valid && (resp_owner == OWNER_INST);
    assign bus.data_data_ok = resp_valid && (resp_owner == OWNER_DATA);
    assign bus.inst_rdata   = bus.inst_data_ok ? bus.sram_rdata : 32'h0;
    assign bus.data_rdata   = bus.data_data_ok ? bus.sram_rdata : 32'h0;

    assign bus.dbg_starve_count = 8'(starve_cnt);
    assign bus.dbg_resp_valid   = resp_valid;
    assign bus.dbg_resp_owner   = resp_owner;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed vector table, hand-written contention and
// reset sequences, then randomized traffic against a reference model.
module tb_sram_arbiter;

    localparam int LIMIT = 4;

    typedef struct {
        logic        inst_req;
        logic [31:0] inst_addr;
        logic        data_req;
        logic [3:0]  data_we;
        logic [31:0] data_addr;
        logic [31:0] data_wdata;
        logic [31:0] sram_rdata;
    } in_t;

    typedef struct {
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        iaok;
        logic        daok;
        logic        idok;
        logic        ddok;
        logic [31:0] irdata;
        logic [31:0] drdata;
        logic        chk_drdata;
    } exp_t;

    typedef struct {
        in_t  in;
        exp_t exp;
    } vec_t;

    logic clk;
    logic resetn;
    int   n_vec;
    int   n_err;

    sram_arbiter_if bus ();

    sram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        bus.inst_req   = v.inst_req;
        bus.inst_addr  = v.inst_addr;
        bus.data_req   = v.data_req;
        bus.data_we    = v.data_we;
        bus.data_addr  = v.data_addr;
        bus.data_wdata = v.data_wdata;
        bus.sram_rdata = v.sram_rdata;
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, ".sram_en"},      32'(bus.sram_en),      32'(e.en));
        check({tag, ".sram_we"},      32'(bus.sram_we),      32'(e.we));
        check({tag, ".sram_addr"},    bus.sram_addr,         e.addr);
        check({tag, ".sram_wdata"},   bus.sram_wdata,        e.wdata);
        check({tag, ".inst_addr_ok"}, 32'(bus.inst_addr_ok), 32'(e.iaok));
        check({tag, ".data_addr_ok"}, 32'(bus.data_addr_ok), 32'(e.daok));
        check({tag, ".inst_data_ok"}, 32'(bus.inst_data_ok), 32'(e.idok));
        check({tag, ".data_data_ok"}, 32'(bus.data_data_ok), 32'(e.ddok));
        check({tag, ".inst_rdata"},   bus.inst_rdata,        e.irdata);
        if (e.chk_drdata) check({tag, ".data_rdata"}, bus.data_rdata, e.drdata);
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e = '{en: 1'b0, we: 4'h0, addr: 32'h0, wdata: 32'h0, iaok: 1'b0, daok: 1'b0,
              idok: 1'b0, ddok: 1'b0, irdata: 32'h0, drdata: 32'h0, chk_drdata: 1'b1};
        return e;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[9];

    // reference model state (random phase)
    int          streak;
    bit          pend_valid;
    bit          pend_data;
    logic [3:0]  pend_we;
    bit          hold_inst;
    bit          hold_data;

    initial begin
        in_t  cur;
        exp_t e;
        int   winner; // 0 none, 1 inst, 2 data

        n_vec = 0;
        n_err = 0;

        //                inst_req inst_addr     data_req we    data_addr  data_wdata   sram_rdata
        vecs[0].in  = '{1'b1, 32'h1C000000, 1'b0, 4'h0, 32'h0,     32'h0,        32'h0};
        vecs[0].exp = '{1'b1, 4'h0, 32'h1C000000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
        vecs[1].in  = '{1'b0, 32'h0,        1'b0, 4'h0, 32'h0,     32'h0,        32'h02800C0C};
        vecs[1].exp = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h02800C0C, 32'h0, 1'b1};
        vecs[2].in  = '{1'b0, 32'h0,        1'b1, 4'hF, 32'h100,   32'hDEADBEEF, 32'h0};
        vecs[2].exp = '{1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
        vecs[3].in  = '{1'b0, 32'h0,        1'b1, 4'h0, 32'h200,   32'h55,       32'h1111};
        vecs[3].exp = '{1'b1, 4'h0, 32'h200, 32'h55, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
        vecs[4].in  = '{1'b1, 32'h1C000004, 1'b0, 4'h0, 32'h0,     32'h0,        32'hAAAA5555};
        vecs[4].exp = '{1'b1, 4'h0, 32'h1C000004, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'hAAAA5555, 1'b1};
        vecs[5].in  = '{1'b0, 32'h0,        1'b0, 4'h0, 32'h0,     32'h0,        32'h12345678};
        vecs[5].exp = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678, 32'h0, 1'b1};
        vecs[6].in  = '{1'b0, 32'h0,        1'b0, 4'h0, 32'h0,     32'h0,        32'hFFFFFFFF};
        vecs[6].exp = idle_exp();
        vecs[7].in  = '{1'b1, 32'h1C000008, 1'b1, 4'h3, 32'h400,   32'hCAFEF00D, 32'h0};
        vecs[7].exp = '{1'b1, 4'h3, 32'h400, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
        vecs[8].in  = '{1'b0, 32'h0,        1'b0, 4'h0, 32'h0,     32'h0,        32'h0BADF00D};
        vecs[8].exp = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};

        // ---- reset: requests high, everything must stay 0 ----
        resetn = 1'b0;
        cur = '{1'b1, 32'h1C000000, 1'b1, 4'hF, 32'h80, 32'h11223344, 32'h99999999};
        drive(cur);
        #2;
        check_all("reset", idle_exp());
        check("reset.starve", 32'(bus.dbg_starve_count), 32'h0);
        check("reset.resp_valid", 32'(bus.dbg_resp_valid), 32'h0);
        check("reset.resp_owner", 32'(bus.dbg_resp_owner), 32'h0);
        next_cycle();
        check_all("reset_after_edge", idle_exp());

        // ---- directed table; first grant in the first cycle after release ----
        resetn = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].in);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].exp);
            next_cycle();
        end

        // ---- contention: data wins LIMIT cycles, then instruction ----
        cur = '{1'b1, 32'h1C000100, 1'b1, 4'h0, 32'h300, 32'h0, 32'h0};
        for (int k = 0; k < 3 * (LIMIT + 1); k++) begin
            bit inst_turn;
            bit prev_inst;
            inst_turn = ((k % (LIMIT + 1)) == LIMIT);
            prev_inst = (k > 0) && (((k - 1) % (LIMIT + 1)) == LIMIT);
            cur.sram_rdata = 32'hC0DE0000 + 32'(k);
            drive(cur);
            @(negedge clk);
            check($sformatf("cont%0d.inst_addr_ok", k), 32'(bus.inst_addr_ok), 32'(inst_turn));
            check($sformatf("cont%0d.data_addr_ok", k), 32'(bus.data_addr_ok), 32'(!inst_turn));
            check($sformatf("cont%0d.sram_addr", k), bus.sram_addr,
                  inst_turn ? 32'h1C000100 : 32'h300);
            check($sformatf("cont%0d.starve", k), 32'(bus.dbg_starve_count), 32'(k % (LIMIT + 1)));
            check($sformatf("cont%0d.inst_data_ok", k), 32'(bus.inst_data_ok), 32'(prev_inst));
            check($sformatf("cont%0d.data_data_ok", k), 32'(bus.data_data_ok),
                  32'((k > 0) && !prev_inst));
            check($sformatf("cont%0d.data_rdata", k), bus.data_rdata,
                  ((k > 0) && !prev_inst) ? cur.sram_rdata : 32'h0);
            next_cycle();
        end
        // last contention cycle was an instruction grant
        cur = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h5A5A5A5A};
        drive(cur);
        @(negedge clk);
        e = idle_exp();
        e.idok = 1'b1;
        e.irdata = 32'h5A5A5A5A;
        check_all("cont_tail", e);
        next_cycle();

        // ---- reset mid-operation ----
        cur = '{1'b1, 32'h1C000200, 1'b1, 4'h0, 32'h500, 32'h0, 32'h77770000};
        drive(cur);
        next_cycle();                 // data granted, count 1
        next_cycle();                 // data granted, count 2
        @(negedge clk);
        check("rst_mid.pre_data_ok", 32'(bus.data_data_ok), 32'h1);
        check("rst_mid.pre_starve", 32'(bus.dbg_starve_count), 32'h2);
        next_cycle();                 // a response is now in flight
        #1;
        resetn = 1'b0;
        #1;
        check_all("rst_mid.async", idle_exp());
        check("rst_mid.starve", 32'(bus.dbg_starve_count), 32'h0);
        next_cycle();
        #2;
        resetn = 1'b1;
        for (int k = 0; k <= LIMIT; k++) begin
            bit inst_turn;
            inst_turn = (k == LIMIT);
            @(negedge clk);
            check($sformatf("rst_rel%0d.inst_addr_ok", k), 32'(bus.inst_addr_ok), 32'(inst_turn));
            check($sformatf("rst_rel%0d.data_addr_ok", k), 32'(bus.data_addr_ok), 32'(!inst_turn));
            check($sformatf("rst_rel%0d.data_data_ok", k), 32'(bus.data_data_ok), 32'(k > 0));
            check($sformatf("rst_rel%0d.inst_data_ok", k), 32'(bus.inst_data_ok), 32'h0);
            next_cycle();
        end
        cur = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0};
        drive(cur);
        @(negedge clk);
        check("rst_rel_tail.inst_data_ok", 32'(bus.inst_data_ok), 32'h1);
        next_cycle();
        @(negedge clk);
        check_all("pre_random_idle", idle_exp());
        next_cycle();

        // ---- randomized traffic against the reference model ----
        streak     = 0;
        pend_valid = 1'b0;
        pend_data  = 1'b0;
        pend_we    = 4'h0;
        hold_inst  = 1'b0;
        hold_data  = 1'b0;
        for (int c = 0; c < 400; c++) begin
            // a denied requester keeps its request and payload
            if (!hold_inst) begin
                cur.inst_req  = ($urandom_range(0, 3) != 0);
                cur.inst_addr = $urandom & 32'hFFFFFFFC;
            end
            if (!hold_data) begin
                cur.data_req   = ($urandom_range(0, 2) != 0);
                cur.data_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                cur.data_addr  = $urandom;
                cur.data_wdata = $urandom;
            end
            cur.sram_rdata = $urandom;
            drive(cur);

            if (cur.inst_req && cur.data_req) winner = (streak >= LIMIT) ? 1 : 2;
            else if (cur.data_req)             winner = 2;
            else if (cur.inst_req)             winner = 1;
            else                               winner = 0;

            e = idle_exp();
            if (winner == 2) begin
                e.en = 1'b1; e.we = cur.data_we; e.addr = cur.data_addr;
                e.wdata = cur.data_wdata; e.daok = 1'b1;
            end else if (winner == 1) begin
                e.en = 1'b1; e.addr = cur.inst_addr; e.iaok = 1'b1;
            end
            e.idok   = pend_valid && !pend_data;
            e.ddok   = pend_valid && pend_data;
            e.irdata = e.idok ? cur.sram_rdata : 32'h0;
            e.drdata = e.ddok ? cur.sram_rdata : 32'h0;
            e.chk_drdata = !(e.ddok && (pend_we != 4'h0));

            @(negedge clk);
            check_all($sformatf("rnd%0d", c), e);
            check($sformatf("rnd%0d.starve", c), 32'(bus.dbg_starve_count), 32'(streak));

            pend_valid = (winner != 0);
            pend_data  = (winner == 2);
            pend_we    = cur.data_we;
            if (cur.inst_req && winner != 1) streak = (streak < LIMIT) ? streak + 1 : LIMIT;
            else                             streak = 0;
            hold_inst = cur.inst_req && (winner != 1);
            hold_data = cur.data_req && (winner != 2);
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
